bird_sprite_compositor: RTL and testbench

Pixel-pipeline stage directly upstream of the bird sprite ROMs (2025 × 16-bit RGB565 words, 45×45 sprite, synchronous read with one-cycle latency, no output register). It generates the ROM read address from the VGA scan position and the bird position. It consumes the returned texel and overlays it onto the background pixel stream using a transparency colour key. It also reports a per-frame collision flag when an opaque bird pixel overlaps a pipe pixel.

---
 rtl/bird_pkg.sv | 20 ++
 rtl/pix_delay.sv | 29 ++
 rtl/bird_sprite_compositor.sv | 135 +++++++++++++
 tb/tb_bird_sprite_compositor.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/bird_pkg.sv
// Shared widths, default sprite geometry and colour key for the bird sprite pipeline.
package bird_pkg;

   localparam int unsigned SPR_W_DEF = 45;
   localparam int unsigned SPR_H_DEF = 45;
   localparam int unsigned PIX_W     = 16;
   localparam int unsigned CNT_W     = 10;
   localparam int unsigned ADDR_W    = 11;

   localparam logic [PIX_W-1:0] KEY_DEF = 16'hF81F;

   typedef logic [PIX_W-1:0]  rgb_t;
   typedef logic [CNT_W-1:0]  cnt_t;
   typedef logic [ADDR_W-1:0] addr_t;

   function automatic logic opaque(input rgb_t texel, input rgb_t key);
      return texel != key;
   endfunction

endpackage

// File: rtl/pix_delay.sv
// N-stage, W-bit shift register with synchronous active-high reset.
module pix_delay #(
   parameter int unsigned N = 3,
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [W-1:0] stage_q [N];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < N; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= din;
         for (int unsigned i = 1; i < N; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign dout = stage_q[N-1];

endmodule

// File: rtl/bird_sprite_compositor.sv
// Generates bird sprite ROM addresses from the scan position, keys the returned texel over
// the background stream and flags per-frame overlap of opaque bird pixels with pipes.
module bird_sprite_compositor
   import bird_pkg::*;
#(
   parameter int unsigned      SPR_W = SPR_W_DEF,
   parameter int unsigned      SPR_H = SPR_H_DEF,
   parameter logic [PIX_W-1:0] KEY   = KEY_DEF
) (
   input  logic              clka,
   input  logic              rsta,
   input  logic              in_de,
   input  logic              in_hs,
   input  logic              in_vs,
   input  logic [CNT_W-1:0]  in_hcnt,
   input  logic [CNT_W-1:0]  in_vcnt,
   input  logic [PIX_W-1:0]  in_rgb,
   input  logic              in_pipe,
   input  logic [CNT_W-1:0]  bird_x,
   input  logic [CNT_W-1:0]  bird_y,
   input  logic [1:0]        anim_sel,
   output logic [ADDR_W-1:0] rom_addr,
   output logic [1:0]        rom_sel,
   input  logic [PIX_W-1:0]  rom_data,
   output logic              out_de,
   output logic              out_hs,
   output logic              out_vs,
   output logic [PIX_W-1:0]  out_rgb,
   output logic              collide
);

   logic       vs_q, de_q;
   cnt_t       x_lat_q, y_lat_q;
   logic [1:0] sel_lat_q;
   addr_t      row_base_q;
   logic       lat_valid_q, hit_acc_q, collide_q;
   addr_t      rom_addr_q;
   rgb_t       out_rgb_q;

   cnt_t row_off, col_off;
   logic in_row, in_col, in_box;
   logic vs_rise, de_fall;
   logic box_d2, pipe_d2, texel_hit, hit_now;
   rgb_t rgb_d2;

   // Offsets wrap, so positions left of / above the sprite fail the range test.
   always_comb begin
      row_off = in_vcnt - y_lat_q;
      col_off = in_hcnt - x_lat_q;
      in_row  = row_off < cnt_t'(SPR_H);
      in_col  = col_off < cnt_t'(SPR_W);
      in_box  = lat_valid_q & in_de & in_row & in_col;
      vs_rise = in_vs & ~vs_q;
      de_fall = de_q & ~in_de;
   end

   pix_delay #(
      .N (3),
      .W (3)
   ) u_timing_dly (
      .clk  (clka),
      .rst  (rsta),
      .din  ({in_de, in_hs, in_vs}),
      .dout ({out_de, out_hs, out_vs})
   );

   pix_delay #(
      .N (2),
      .W (PIX_W)
   ) u_rgb_dly (
      .clk  (clka),
      .rst  (rsta),
      .din  (in_rgb),
      .dout (rgb_d2)
   );

   pix_delay #(
      .N (2),
      .W (2)
   ) u_flag_dly (
      .clk  (clka),
      .rst  (rsta),
      .din  ({in_box, in_pipe}),
      .dout ({box_d2, pipe_d2})
   );

   always_comb begin
      texel_hit = box_d2 & opaque(rom_data, KEY);
      hit_now   = texel_hit & pipe_d2;
   end

   always_ff @(posedge clka) begin
      if (rsta) begin
         vs_q        <= 1'b0;
         de_q        <= 1'b0;
         x_lat_q     <= '0;
         y_lat_q     <= '0;
         sel_lat_q   <= '0;
         row_base_q  <= '0;
         lat_valid_q <= 1'b0;
         hit_acc_q   <= 1'b0;
         collide_q   <= 1'b0;
         rom_addr_q  <= '0;
         out_rgb_q   <= '0;
      end else begin
         vs_q       <= in_vs;
         de_q       <= in_de;
         rom_addr_q <= in_box ? row_base_q + addr_t'(col_off[5:0]) : '0;
         out_rgb_q  <= texel_hit ? rom_data : rgb_d2;
         if (vs_rise) begin
            x_lat_q     <= bird_x;
            y_lat_q     <= bird_y;
            sel_lat_q   <= anim_sel;
            row_base_q  <= '0;
            lat_valid_q <= 1'b1;
            collide_q   <= hit_acc_q;
            // A hit landing on the latch cycle belongs to the new frame.
            hit_acc_q   <= hit_now;
         end else begin
            collide_q <= 1'b0;
            hit_acc_q <= hit_acc_q | hit_now;
            // Advance per line even when columns are clipped, keeping the stride exact.
            if (de_fall && in_row) begin
               row_base_q <= row_base_q + addr_t'(SPR_W);
            end
         end
      end
   end

   assign rom_addr = rom_addr_q;
   assign rom_sel  = sel_lat_q;
   assign out_rgb  = out_rgb_q;
   assign collide  = collide_q;

endmodule

// File: tb/tb_bird_sprite_compositor.sv
// Directed bench for bird_sprite_compositor: per-cycle reference model plus hand-valued probes.
module tb_bird_sprite_compositor;

   localparam logic [15:0] KEY = 16'hF81F;

   logic        clka = 1'b0;
   logic        rsta, in_de, in_hs, in_vs, in_pipe;
   logic [9:0]  in_hcnt, in_vcnt, bird_x, bird_y;
   logic [15:0] in_rgb, rom_data, out_rgb;
   logic [1:0]  anim_sel, rom_sel;
   logic [10:0] rom_addr;
   logic        out_de, out_hs, out_vs, collide;

   bird_sprite_compositor dut (
      .clka     (clka),
      .rsta     (rsta),
      .in_de    (in_de),
      .in_hs    (in_hs),
      .in_vs    (in_vs),
      .in_hcnt  (in_hcnt),
      .in_vcnt  (in_vcnt),
      .in_rgb   (in_rgb),
      .in_pipe  (in_pipe),
      .bird_x   (bird_x),
      .bird_y   (bird_y),
      .anim_sel (anim_sel),
      .rom_addr (rom_addr),
      .rom_sel  (rom_sel),
      .rom_data (rom_data),
      .out_de   (out_de),
      .out_hs   (out_hs),
      .out_vs   (out_vs),
      .out_rgb  (out_rgb),
      .collide  (collide)
   );

   always #5 clka = ~clka;

   typedef struct packed {
      logic        de, hs, vs, hit;
      logic [9:0]  h, v;
      logic [15:0] rgb;
   } exp_t;

   int          total = 0;
   int          bad = 0;
   int          rom_mode = 0;
   int          pulses = 0;
   logic [9:0]  pipe_lo = 10'd1023, pipe_hi = 10'd0;
   exp_t        e0, e1, e2;
   logic        lat_m, hit_m, vsq_m;
   logic [9:0]  x_m, y_m;
   logic [1:0]  sel_m;
   logic [10:0] max_addr;
   logic [9:0]  rph [3], rpv [3], aph [2], apv [2];
   logic [15:0] rpval [3];
   logic [10:0] apval [2];

   function automatic logic [15:0] rommodel(input logic [10:0] a);
      if (rom_mode == 1 && !a[0]) return KEY;
      return {5'd0, a};
   endfunction

   function automatic logic [15:0] bgf(input logic [9:0] h, input logic [9:0] v);
      return ({6'd0, h} * 16'd7) ^ ({6'd0, v} << 6) ^ 16'h1234;
   endfunction

   // Synchronous ROM, one-cycle latency, no output register beyond the read.
   always @(posedge clka) rom_data <= rommodel(rom_addr);

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
      total++;
      assert (got === want)
      else begin
         bad++;
         $error("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   task automatic step();
      exp_t        n;
      logic [9:0]  ro, co;
      logic        box, vs_rise, exp_col;
      logic [10:0] a;
      logic [15:0] d, exp_addr;
      in_rgb = bgf(in_hcnt, in_vcnt);
      if (rsta) begin
         e0 = '0; e1 = '0; e2 = '0;
         lat_m = 1'b0; hit_m = 1'b0; vsq_m = 1'b0;
         x_m = '0; y_m = '0; sel_m = '0;
         exp_addr = '0; exp_col = 1'b0;
      end else begin
         ro  = in_vcnt - y_m;
         co  = in_hcnt - x_m;
         box = lat_m && in_de && ro < 10'd45 && co < 10'd45;
         a   = box ? 11'(ro) * 11'd45 + 11'(co) : 11'd0;
         d   = rommodel(a);
         n.de = in_de; n.hs = in_hs; n.vs = in_vs; n.h = in_hcnt; n.v = in_vcnt;
         n.rgb = (box && d != KEY) ? d : in_rgb;
         n.hit = box && d != KEY && in_pipe;
         e2 = e1; e1 = e0; e0 = n;
         vs_rise = in_vs && !vsq_m;
         vsq_m = in_vs;
         if (vs_rise) begin
            exp_col = hit_m; hit_m = e2.hit;
            lat_m = 1'b1; x_m = bird_x; y_m = bird_y; sel_m = anim_sel;
         end else begin
            exp_col = 1'b0; hit_m = hit_m | e2.hit;
         end
         exp_addr = {5'd0, a};
      end
      @(posedge clka);
      #1;
      chk("out_rgb", out_rgb, e2.rgb);
      chk("out_de", {15'd0, out_de}, {15'd0, e2.de});
      chk("out_hs", {15'd0, out_hs}, {15'd0, e2.hs});
      chk("out_vs", {15'd0, out_vs}, {15'd0, e2.vs});
      chk("rom_addr", {5'd0, rom_addr}, exp_addr);
      chk("rom_sel", {14'd0, rom_sel}, {14'd0, sel_m});
      chk("collide", {15'd0, collide}, {15'd0, exp_col});
      if (collide) pulses++;
      if (rom_addr > max_addr) max_addr = rom_addr;
      for (int i = 0; i < 3; i++)
         if (e2.de && e2.h == rph[i] && e2.v == rpv[i]) rpval[i] = out_rgb;
      for (int i = 0; i < 2; i++)
         if (in_de && in_hcnt == aph[i] && in_vcnt == apv[i]) apval[i] = rom_addr;
   endtask

   task automatic line(input logic [9:0] v, input logic [9:0] h0, input logic [9:0] h1);
      for (int h = int'(h0); h <= int'(h1); h++) begin
         in_de = 1'b1; in_hs = 1'b0; in_vs = 1'b0;
         in_hcnt = 10'(h); in_vcnt = v;
         in_pipe = (10'(h) >= pipe_lo) && (10'(h) <= pipe_hi);
         step();
      end
      for (int i = 0; i < 4; i++) begin
         in_de = 1'b0; in_hs = (i == 1 || i == 2); in_pipe = 1'b0;
         in_hcnt = 10'(int'(h1) + 1 + i);
         step();
      end
   endtask

   task automatic frame(input logic [9:0] v0, input logic [9:0] v1,
                        input logic [9:0] h0, input logic [9:0] h1);
      for (int v = int'(v0); v <= int'(v1); v++) line(10'(v), h0, h1);
   endtask

   task automatic vsync();
      in_de = 1'b0; in_hs = 1'b0; in_pipe = 1'b0; in_hcnt = '0; in_vcnt = '0;
      for (int i = 0; i < 5; i++) begin
         in_vs = (i < 3);
         step();
      end
   endtask

   task automatic set_probes(input logic [9:0] h0, input logic [9:0] v0,
                             input logic [9:0] h1, input logic [9:0] v1,
                             input logic [9:0] h2, input logic [9:0] v2);
      rph[0] = h0; rpv[0] = v0; rph[1] = h1; rpv[1] = v1; rph[2] = h2; rpv[2] = v2;
      for (int i = 0; i < 3; i++) rpval[i] = 16'hDEAD;
   endtask

   initial begin
      rsta = 1'b1; in_de = 0; in_hs = 0; in_vs = 0; in_pipe = 0;
      in_hcnt = '0; in_vcnt = '0; in_rgb = '0;
      bird_x = '0; bird_y = '0; anim_sel = '0;
      for (int i = 0; i < 2; i++) begin aph[i] = 10'd1023; apv[i] = 10'd1023; apval[i] = '1; end
      set_probes(10'd1023, 10'd1023, 10'd1023, 10'd1023, 10'd1023, 10'd1023);

      // Reset, then video with no vs edge: background only, address held at 0.
      for (int i = 0; i < 5; i++) step();
      rsta = 1'b0;
      max_addr = '0; pulses = 0;
      frame(10'd0, 10'd3, 10'd0, 10'd20);
      chk("reset_max_addr", {5'd0, max_addr}, 16'd0);
      chk("reset_pulses", 16'(pulses), 16'd0);

      // Full opaque sprite at (100,200), ROM data = address.
      bird_x = 10'd100; bird_y = 10'd200; anim_sel = 2'd1; rom_mode = 0;
      vsync();
      set_probes(10'd100, 10'd200, 10'd144, 10'd244, 10'd145, 10'd200);
      frame(10'd195, 10'd250, 10'd95, 10'd150);
      chk("full_first", rpval[0], 16'd0);
      chk("full_last", rpval[1], 16'd2024);
      chk("full_right_bg", rpval[2], bgf(10'd145, 10'd200));

      // Even texels keyed out; pipe over columns 110..120; bird_x moved mid-frame.
      rom_mode = 1; pipe_lo = 10'd110; pipe_hi = 10'd120;
      vsync();
      set_probes(10'd100, 10'd200, 10'd101, 10'd200, 10'd102, 10'd230);
      frame(10'd195, 10'd210, 10'd95, 10'd150);
      bird_x = 10'd300;
      frame(10'd211, 10'd250, 10'd95, 10'd150);
      chk("key_even_bg", rpval[0], bgf(10'd100, 10'd200));
      chk("key_odd_tex", rpval[1], 16'd1);
      chk("key_moved_late", rpval[2], bgf(10'd102, 10'd230));

      // Collision from previous frame reported once; reset mid-sprite blanks the rest.
      rom_mode = 0; pipe_lo = 10'd1023; pipe_hi = 10'd0; pulses = 0;
      vsync();
      chk("collide_pulses", 16'(pulses), 16'd1);
      set_probes(10'd300, 10'd200, 10'd300, 10'd230, 10'd344, 10'd219);
      frame(10'd195, 10'd219, 10'd295, 10'd350);
      in_de = 1'b1; in_hcnt = 10'd310; in_vcnt = 10'd220; rsta = 1'b1;
      step();
      chk("rst_out_rgb", out_rgb, 16'd0);
      chk("rst_collide", {15'd0, collide}, 16'd0);
      rsta = 1'b0;
      frame(10'd220, 10'd250, 10'd295, 10'd350);
      chk("moved_first", rpval[0], 16'd0);
      chk("after_rst_bg", rpval[1], bgf(10'd300, 10'd230));
      chk("moved_row19", rpval[2], 16'd899);

      // Right/bottom clipping at (620,460), no pipe: no pulse expected.
      bird_x = 10'd620; bird_y = 10'd460; anim_sel = 2'd2; pulses = 0;
      vsync();
      chk("no_pipe_pulses", 16'(pulses), 16'd0);
      aph[0] = 10'd620; apv[0] = 10'd461; aph[1] = 10'd639; apv[1] = 10'd460;
      max_addr = '0;
      frame(10'd455, 10'd479, 10'd600, 10'd639);
      chk("clip_row461", {5'd0, apval[0]}, 16'd45);
      chk("clip_row460_end", {5'd0, apval[1]}, 16'd19);
      chk("clip_max_addr", {5'd0, max_addr}, 16'd874);
      chk("clip_sel", {14'd0, rom_sel}, 16'd2);
      pulses = 0;
      vsync();
      chk("clip_pulses", 16'(pulses), 16'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
